// File: rtl/bls12_381_fe12_stream_rx_if.sv
// Beat-level stream interface carrying one Fp element per beat plus sop/eop framing and a ctl side field.
interface if_axi_stream #(
    parameter int unsigned DAT_BITS = 381,
    parameter int unsigned CTL_BITS = 32
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport source (output val, sop, eop, dat, ctl, input rdy);
    modport sink   (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/bls12_381_fe12_stream_rx.sv
// Deframer: assembles 12 Fp beats into one Fp12 word, checks sop/eop framing, and hands the word
// downstream through a val/rdy port. It has one assembly slot and one output slot.
package bls12_381_fe12_pkg;
    localparam int unsigned FE_BITS    = 381;
    localparam int unsigned FE12_BEATS = 12;
    typedef logic [FE_BITS-1:0]                  fe_t;
    typedef logic [FE12_BEATS-1:0][FE_BITS-1:0]  fe12_t;
endpackage

module bls12_381_fe12_stream_rx #(
    parameter type         FE_TYPE      = bls12_381_fe12_pkg::fe_t,
    parameter type         FE12_TYPE    = bls12_381_fe12_pkg::fe12_t,
    parameter int unsigned CTL_BITS     = 32,
    parameter int unsigned ERR_CNT_BITS = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    if_axi_stream.sink              i_fe12_if,
    output FE12_TYPE                o_fe12,
    output logic [CTL_BITS-1:0]     o_ctl,
    output logic                    o_val,
    input  logic                    i_rdy,
    output logic                    o_err,
    output logic [ERR_CNT_BITS-1:0] o_err_cnt
);
    localparam int unsigned FE_BITS  = $bits(FE_TYPE);
    localparam int unsigned BEATS    = 12;
    localparam int unsigned CNT_BITS = 4;
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

    typedef logic [BEATS-1:0][FE_BITS-1:0] slot_t;

    logic [CNT_BITS-1:0]     cnt_q, cnt_d;
    slot_t                   asm_q, asm_d;
    logic [CTL_BITS-1:0]     asm_ctl_q, asm_ctl_d;
    logic                    asm_full_q, asm_full_d;
    slot_t                   out_q, out_d;
    logic [CTL_BITS-1:0]     out_ctl_q, out_ctl_d;
    logic                    out_val_q, out_val_d;
    logic                    rdy_q, rdy_d;
    logic                    err_q, err_d;
    logic [ERR_CNT_BITS-1:0] err_cnt_q, err_cnt_d;

    logic accept;
    logic drain;
    logic complete;
    logic move_held;

    // State register: everything, including the outputs, clears on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            asm_q      <= '0;
            asm_ctl_q  <= '0;
            asm_full_q <= 1'b0;
            out_q      <= '0;
            out_ctl_q  <= '0;
            out_val_q  <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            asm_ctl_q  <= asm_ctl_d;
            asm_full_q <= asm_full_d;
            out_q      <= out_d;
            out_ctl_q  <= out_ctl_d;
            out_val_q  <= out_val_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Beat framing: cnt is the frame state (0 idle, 1..11 collecting).
    always_comb begin
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        asm_ctl_d = asm_ctl_q;
        err_d     = 1'b0;
        complete  = 1'b0;
        accept    = i_fe12_if.val && rdy_q;
        if (accept) begin
            if (i_fe12_if.sop) begin
                err_d     = (cnt_q != '0) || i_fe12_if.eop;
                asm_d[0]  = FE_BITS'(i_fe12_if.dat);
                asm_ctl_d = i_fe12_if.ctl;
                cnt_d     = i_fe12_if.eop ? '0 : CNT_BITS'(1);
            end else if (cnt_q == '0) begin
                err_d = 1'b1;
            end else if (i_fe12_if.eop != (cnt_q == LAST_BEAT)) begin
                err_d = 1'b1;
                cnt_d = '0;
            end else begin
                asm_d[cnt_q] = FE_BITS'(i_fe12_if.dat);
                if (i_fe12_if.eop) begin
                    complete = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
        end
    end

    // Slot movement, input ready and error counter.
    always_comb begin
        out_d      = out_q;
        out_ctl_d  = out_ctl_q;
        out_val_d  = out_val_q;
        asm_full_d = asm_full_q;
        err_cnt_d  = err_cnt_q;
        move_held  = 1'b0;
        drain      = out_val_q && i_rdy;
        if (drain) begin
            out_val_d = 1'b0;
        end
        if (complete) begin
            if (!out_val_q || drain) begin
                out_d     = asm_d;
                out_ctl_d = asm_ctl_d;
                out_val_d = 1'b1;
            end else begin
                asm_full_d = 1'b1;
            end
        end else if (asm_full_q && drain) begin
            out_d      = asm_q;
            out_ctl_d  = asm_ctl_q;
            out_val_d  = 1'b1;
            asm_full_d = 1'b0;
            move_held  = 1'b1;
        end
        // Ready reopens one cycle after a held frame leaves the assembly slot.
        rdy_d = !asm_full_d && !move_held;
        if (err_d && (err_cnt_q != {ERR_CNT_BITS{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_BITS'(1);
        end
    end

    assign i_fe12_if.rdy = rdy_q;
    assign o_fe12        = FE12_TYPE'(out_q);
    assign o_ctl         = out_ctl_q;
    assign o_val         = out_val_q;
    assign o_err         = err_q;
    assign o_err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_bls12_381_fe12_stream_rx.sv
// Bench for the Fp12 stream deframer: directed frames, a frame-level reference model and per-cycle output checks.
module tb_bls12_381_fe12_stream_rx;
    import bls12_381_fe12_pkg::*;

    typedef struct {
        fe12_t       d;
        logic [31:0] c;
    } frm_t;

    logic        clk;
    logic        rst_n;
    logic        i_rdy;
    fe12_t       o_fe12;
    logic [31:0] o_ctl;
    logic        o_val;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    if_axi_stream #(.DAT_BITS(381), .CTL_BITS(32)) s_if ();

    bls12_381_fe12_stream_rx dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_fe12_if (s_if),
        .o_fe12    (o_fe12),
        .o_ctl     (o_ctl),
        .o_val     (o_val),
        .i_rdy     (i_rdy),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    frm_t        expq[$];
    fe_t         part[$];
    logic [31:0] pctl;
    logic        exp_err;
    int          exp_cnt;
    int          cyc;
    int          deliveries;
    int          dv_cyc[$];
    logic [63:0] last_c0;
    logic        rdy_low_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_fe12(input string name, input fe12_t act, input fe12_t exp);
        checks++;
        for (int k = 0; k < 12; k++) begin
            if (act[k] !== exp[k]) begin
                errors++;
                $display("FAIL %s coef %0d got %h want %h (t=%0t)", name, k, act[k][63:0], exp[k][63:0], $time);
                break;
            end
        end
    endtask

    // Frame-level model of one accepted beat; returns whether it is a framing error.
    function automatic logic model_beat(input logic sop, input logic eop, input fe_t dat, input logic [31:0] ctl);
        frm_t f;
        logic e;
        e = 1'b0;
        if (sop) begin
            e = (part.size() != 0) || eop;
            part.delete();
            pctl = ctl;
            if (!eop) part.push_back(dat);
        end else if (part.size() == 0) begin
            e = 1'b1;
        end else if (eop && part.size() != 11) begin
            e = 1'b1;
            part.delete();
        end else if (!eop && part.size() == 11) begin
            e = 1'b1;
            part.delete();
        end else begin
            part.push_back(dat);
            if (eop) begin
                for (int k = 0; k < 12; k++) f.d[k] = part[k];
                f.c = pctl;
                expq.push_back(f);
                part.delete();
            end
        end
        return e;
    endfunction

    // Compare process: checks outputs every cycle, then advances the model.
    initial begin
        cyc = 0;
        deliveries = 0;
        exp_err = 1'b0;
        exp_cnt = 0;
        rdy_low_seen = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                expq.delete();
                part.delete();
                exp_err = 1'b0;
                exp_cnt = 0;
            end else begin
                if (!s_if.rdy) rdy_low_seen = 1'b1;
                chk("err_pulse", 64'(o_err), 64'(exp_err));
                chk("err_cnt", 64'(o_err_cnt), 64'(exp_cnt));
                chk("o_val", 64'(o_val), 64'(expq.size() != 0));
                if (o_val && expq.size() != 0) begin
                    chk_fe12("o_fe12", o_fe12, expq[0].d);
                    chk("o_ctl", 64'(o_ctl), 64'(expq[0].c));
                    if (i_rdy) begin
                        last_c0 = expq[0].d[0][63:0];
                        void'(expq.pop_front());
                        deliveries++;
                        dv_cyc.push_back(cyc);
                    end
                end
                exp_err = 1'b0;
                if (s_if.val && s_if.rdy) begin
                    exp_err = model_beat(s_if.sop, s_if.eop, s_if.dat, s_if.ctl);
                end
                if (exp_err && exp_cnt != 255) exp_cnt++;
            end
        end
    end

    // Drive one beat starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic send_beat(input logic sop, input logic eop, input fe_t dat, input logic [31:0] ctl);
        int n;
        s_if.val = 1'b1;
        s_if.sop = sop;
        s_if.eop = eop;
        s_if.dat = dat;
        s_if.ctl = ctl;
        n = 0;
        @(negedge clk);
        while (!s_if.rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_if.rdy) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout rdy got 0 want 1 (t=%0t)", $time);
        end
        @(posedge clk);
        #1;
        s_if.val = 1'b0;
        s_if.sop = 1'b0;
        s_if.eop = 1'b0;
    endtask

    function automatic fe_t mk(input int base, input int k, input logic [31:0] hi);
        fe_t d;
        d = fe_t'(base + k);
        d[380:349] = hi;
        return d;
    endfunction

    // Beats lo..hi of a frame; sop on 0, eop on beat `eop_at` (-1 for none).
    task automatic send_beats(input int base, input logic [31:0] ctl, input logic [31:0] hi,
                              input int lo, input int hi_k, input int eop_at);
        for (int k = lo; k <= hi_k; k++) begin
            send_beat(k == 0, k == eop_at, mk(base, k, hi), ctl);
        end
    endtask

    task automatic send_frame(input int base, input logic [31:0] ctl, input logic [31:0] hi);
        send_beats(base, ctl, hi, 0, 11, 11);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    int d0;
    int n0;

    initial begin
        rst_n = 1'b0;
        i_rdy = 1'b0;
        s_if.val = 1'b0;
        s_if.sop = 1'b0;
        s_if.eop = 1'b0;
        s_if.dat = '0;
        s_if.ctl = '0;

        // Reset state
        idle(3);
        chk("rst_o_val", 64'(o_val), 64'd0);
        chk("rst_o_err", 64'(o_err), 64'd0);
        chk("rst_err_cnt", 64'(o_err_cnt), 64'd0);
        chk("rst_rdy", 64'(s_if.rdy), 64'd0);
        chk("rst_o_fe12_c0", o_fe12[0][63:0], 64'd0);
        chk("rst_o_ctl", 64'(o_ctl), 64'd0);
        rst_n = 1'b1;
        chk("rdy_at_release", 64'(s_if.rdy), 64'd0);
        idle(1);
        chk("rdy_after_release", 64'(s_if.rdy), 64'd1);

        // 1: single frame dat=k+1, ctl=0x5A
        i_rdy = 1'b1;
        send_frame(1, 32'h5A, 32'h0);
        chk("t1_o_val", 64'(o_val), 64'd1);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("t1_coef%0d", k), o_fe12[k][63:0], 64'(k + 1));
        end
        chk("t1_coef11_hi", 64'(o_fe12[11][380:349]), 64'd0);
        chk("t1_o_ctl", 64'(o_ctl), 64'h5A);
        idle(2);
        chk("t1_err_cnt", 64'(o_err_cnt), 64'd0);

        // 2: three frames back to back
        rdy_low_seen = 1'b0;
        n0 = dv_cyc.size();
        send_frame(32'h100, 32'h11, 32'hDEADBEEF);
        send_frame(32'h200, 32'h22, 32'hCAFEF00D);
        send_frame(32'h300, 32'h33, 32'h12345678);
        idle(2);
        chk("t2_count", 64'(dv_cyc.size() - n0), 64'd3);
        if (dv_cyc.size() - n0 == 3) begin
            chk("t2_gap1", 64'(dv_cyc[n0 + 1] - dv_cyc[n0]), 64'd12);
            chk("t2_gap2", 64'(dv_cyc[n0 + 2] - dv_cyc[n0 + 1]), 64'd12);
        end
        chk("t2_rdy_low", 64'(rdy_low_seen), 64'd0);

        // 3: output stalled, second frame held in assembly
        i_rdy = 1'b0;
        send_frame(32'h400, 32'hA1, 32'h1);
        send_frame(32'h500, 32'hA2, 32'h2);
        chk("t3_rdy_held", 64'(s_if.rdy), 64'd0);
        chk("t3_o_val", 64'(o_val), 64'd1);
        chk("t3_first_c0", o_fe12[0][63:0], 64'h400);
        idle(3);
        chk("t3_still_first", o_fe12[0][63:0], 64'h400);
        i_rdy = 1'b1;
        idle(1);
        chk("t3_rdy_after_move", 64'(s_if.rdy), 64'd0);
        chk("t3_second_c0", o_fe12[0][63:0], 64'h500);
        chk("t3_second_ctl", 64'(o_ctl), 64'hA2);
        idle(1);
        chk("t3_rdy_back", 64'(s_if.rdy), 64'd1);
        chk("t3_drained", 64'(o_val), 64'd0);

        // 4: truncated frame followed by a fresh sop
        d0 = deliveries;
        send_beats(32'h600, 32'hB0, 32'h3, 0, 4, -1);
        send_frame(32'h700, 32'hB1, 32'h4);
        idle(2);
        chk("t4_err_cnt", 64'(o_err_cnt), 64'd1);
        chk("t4_deliveries", 64'(deliveries - d0), 64'd1);
        chk("t4_last_c0", last_c0, 64'h700);

        // 5: framing error cases
        do_reset();
        d0 = deliveries;
        send_beats(32'h800, 32'hC0, 32'h5, 0, 7, 7);
        send_beat(1'b0, 1'b0, mk(32'h900, 0, 32'h6), 32'hC1);
        send_beats(32'hA00, 32'hC2, 32'h7, 0, 11, -1);
        idle(2);
        chk("t5_err_cnt", 64'(o_err_cnt), 64'd3);
        chk("t5_deliveries", 64'(deliveries - d0), 64'd0);

        // 6: async reset mid-frame with a frame waiting at the output
        i_rdy = 1'b0;
        send_frame(32'hB00, 32'hD0, 32'h8);
        send_beats(32'hC00, 32'hD1, 32'h9, 0, 4, -1);
        chk("t6_val_before", 64'(o_val), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_val_async", 64'(o_val), 64'd0);
        chk("t6_rdy_async", 64'(s_if.rdy), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        i_rdy = 1'b1;
        d0 = deliveries;
        send_frame(32'hD00, 32'hD2, 32'hA);
        idle(2);
        chk("t6_deliveries", 64'(deliveries - d0), 64'd1);
        chk("t6_last_c0", last_c0, 64'hD00);
        chk("t6_err_cnt", 64'(o_err_cnt), 64'd0);
        for (int i = 0; i < 300; i++) begin
            send_beat(1'b0, 1'b0, mk(i, 0, 32'h0), 32'h0);
        end
        idle(2);
        chk("t6_err_sat", 64'(o_err_cnt), 64'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule
